// File: rtl/hack_cpu_ctrl_if.sv
// hack_cpu_ctrl_if: ROM, RAM and ALU signals between the Hack CPU control stage and its environment.
interface hack_cpu_ctrl_if #(parameter int PC_W = 15);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [15:0]     dmem_addr;
  logic [15:0]     dmem_rdata;
  logic [15:0]     dmem_wdata;
  logic            dmem_we;
  logic [15:0]     alu_x;
  logic [15:0]     alu_y;
  logic            alu_zx;
  logic            alu_nx;
  logic            alu_zy;
  logic            alu_ny;
  logic            alu_f;
  logic            alu_no;
  logic [15:0]     alu_out;
  logic            alu_zr;
  logic            alu_ng;
  logic            halted;
  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_x, alu_y,
           alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, halted,
    input  imem_data, dmem_rdata, alu_out, alu_zr, alu_ng
  );
  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we, alu_x, alu_y,
           alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, halted,
    output imem_data, dmem_rdata, alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU control/datapath feeding an external combinational ALU.
// Optional HACK_HALT_DETECT_EN: a taken self-jump parks the CPU in HALT until reset.
module hack_cpu_ctrl #(
  parameter int              PC_W      = 15,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic            clk,
  input logic            reset,
  hack_cpu_ctrl_if.master bus
);
`ifdef HACK_HALT_DETECT_EN
  typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXEC, HALT} state_e;
`else
  typedef enum logic [2:0] {FETCH, DECODE, MREAD, EXEC} state_e;
`endif
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     a_q, a_d, d_q, d_d, m_q, m_d;
  logic [12:0]     ir_q, ir_d;
  logic            we, take;
  assign take = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) | (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    ir_d    = ir_q;
    we      = 1'b0;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d = bus.imem_data[12:0];
        if (!bus.imem_data[15]) begin
          a_d     = bus.imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = FETCH;
        end else state_d = bus.imem_data[12] ? MREAD : EXEC;
      end
      MREAD: begin
        m_d     = bus.dmem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        a_d     = ir_q[5] ? bus.alu_out : a_q;
        d_d     = ir_q[4] ? bus.alu_out : d_q;
        we      = ir_q[3];
        pc_d    = take ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
        state_d = FETCH;
`ifdef HACK_HALT_DETECT_EN
        if (take && a_q[PC_W-1:0] == pc_q) state_d = HALT;
`endif
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VEC;
      a_q     <= '0;
      d_q     <= '0;
      m_q     <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      ir_q    <= ir_d;
    end
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = a_q;
  assign bus.dmem_we    = we;
  assign bus.dmem_wdata = we ? bus.alu_out : '0;
  assign bus.alu_x      = d_q;
  assign bus.alu_y      = ir_q[12] ? m_q : a_q;
  assign {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} = ir_q[11:6];
`ifdef HACK_HALT_DETECT_EN
  assign bus.halted = state_q == HALT;
`else
  assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// tb_hack_cpu_ctrl: directed program vectors against hack_cpu_ctrl with bench-side ROM, RAM and Hack ALU.
module tb_hack_cpu_ctrl;
  logic clk, reset;
  hack_cpu_ctrl_if #(.PC_W(15)) bus();
  hack_cpu_ctrl #(.PC_W(15), .RESET_VEC(15'd0)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:255];
  logic        poke;
  logic [7:0]  poke_a;
  logic [15:0] poke_d;
  int          we_cnt;
  always @(posedge clk) begin
    bus.imem_data  <= rom[bus.imem_addr];
    bus.dmem_rdata <= ram[bus.dmem_addr[7:0]];
    if (poke) ram[poke_a] <= poke_d;
    else if (bus.dmem_we) ram[bus.dmem_addr[7:0]] <= bus.dmem_wdata;
    if (reset) we_cnt <= 0;
    else if (bus.dmem_we) we_cnt <= we_cnt + 1;
  end
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = bus.alu_zx ? 16'h0 : bus.alu_x;
    ax = bus.alu_nx ? ~ax : ax;
    ay = bus.alu_zy ? 16'h0 : bus.alu_y;
    ay = bus.alu_ny ? ~ay : ay;
    ao = bus.alu_f ? ax + ay : ax & ay;
    ao = bus.alu_no ? ~ao : ao;
    bus.alu_out = ao;
    bus.alu_zr  = ao == 16'h0;
    bus.alu_ng  = ao[15];
  end
  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask
  task automatic poke_ram(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke = 1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke = 0;
  endtask
  task automatic load4(input logic [15:0] p0, p1, p2, p3);
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
  endtask
  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, p3;
    int          cycles;
    logic [14:0] pc;
    logic [15:0] a, d;
    int          we;
  } vec_t;
  vec_t tv [9];
  initial begin
    reset = 1; poke = 0; poke_a = 0; poke_d = 0;
    for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
    tv[0] = '{"ld_a",  16'h0005, 16'hEC10, 16'h0000, 16'h0000, 5,  15'd2, 16'd5,   16'd5,    0};
    tv[1] = '{"add",   16'h0007, 16'hEC10, 16'h0003, 16'hE090, 10, 15'd4, 16'd3,   16'd10,   0};
    tv[2] = '{"jlt",   16'hEE90, 16'h0008, 16'hE304, 16'h0000, 8,  15'd8, 16'd8,   16'hFFFF, 0};
    tv[3] = '{"jgt",   16'hEE90, 16'h0008, 16'hE301, 16'h0000, 8,  15'd3, 16'd8,   16'hFFFF, 0};
    tv[4] = '{"m_wr",  16'h000A, 16'hEC10, 16'h0064, 16'hE308, 10, 15'd4, 16'd100, 16'd10,   1};
    tv[5] = '{"m_rd",  16'h0064, 16'hFC10, 16'h0000, 16'h0000, 6,  15'd2, 16'd100, 16'd10,   0};
    tv[6] = '{"a_jmp", 16'h0007, 16'hEDE7, 16'h0000, 16'h0000, 5,  15'd7, 16'd8,   16'd0,    0};
    tv[7] = '{"am",    16'h0005, 16'hEC10, 16'h0014, 16'hE328, 10, 15'd4, 16'd5,   16'd5,    1};
    tv[8] = '{"ad",    16'h0009, 16'hEDF0, 16'h0000, 16'h0000, 5,  15'd2, 16'd10,  16'd10,   0};
    do_reset();
    chk("rst_pc", 32'(bus.imem_addr), 0);
    chk("rst_halt", 32'(bus.halted), 0);
    chk("rst_we", 32'(bus.dmem_we), 0);
    chk("rst_wdata", 32'(bus.dmem_wdata), 0);
    chk("rst_ctl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 0);
    chk("rst_d", 32'(bus.alu_x), 0);
    for (int i = 0; i < 9; i++) begin
      load4(tv[i].p0, tv[i].p1, tv[i].p2, tv[i].p3);
      do_reset();
      cyc(tv[i].cycles);
      chk({tv[i].name, "_pc"}, 32'(bus.imem_addr), 32'(tv[i].pc));
      chk({tv[i].name, "_a"}, 32'(bus.dmem_addr), 32'(tv[i].a));
      chk({tv[i].name, "_d"}, 32'(bus.alu_x), 32'(tv[i].d));
      chk({tv[i].name, "_we"}, 32'(we_cnt), 32'(tv[i].we));
    end
    chk("am_ram20", 32'(ram[20]), 5);
    load4(16'h0005, 16'hEC10, 16'h0000, 16'h0000);
    do_reset();
    cyc(4);
    chk("exec_ctl", 32'({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no}), 32'b110000);
    chk("exec_y", 32'(bus.alu_y), 5);
    chk("exec_we", 32'(bus.dmem_we), 0);
    poke_ram(8'd100, 16'd10);
    load4(16'h0064, 16'hFC10, 16'h0000, 16'h0000);
    do_reset();
    cyc(5);
    chk("mrd_lat5", 32'(bus.alu_x), 0);
    cyc(1);
    chk("mrd_lat6", 32'(bus.alu_x), 10);
    poke_ram(8'd100, 16'h0055);
    load4(16'h000A, 16'hEC10, 16'h0064, 16'hE308);
    do_reset();
    cyc(9);
    chk("mwr_we", 32'(bus.dmem_we), 1);
    chk("mwr_addr", 32'(bus.dmem_addr), 100);
    chk("mwr_wdata", 32'(bus.dmem_wdata), 10);
    #1 reset = 1;
    #1;
    chk("arst_we", 32'(bus.dmem_we), 0);
    chk("arst_pc", 32'(bus.imem_addr), 0);
    chk("arst_a", 32'(bus.dmem_addr), 0);
    @(negedge clk);
    reset = 0;
    chk("arst_ram", 32'(ram[100]), 16'h0055);
    chk("arst_cnt", 32'(we_cnt), 0);
    load4(16'h7FFF, 16'hEA87, 16'h0000, 16'h0000);
    rom[32767] = 16'h0003;
    do_reset();
    cyc(5);
    chk("wrap_top", 32'(bus.imem_addr), 32'h7FFF);
    cyc(2);
    chk("wrap_pc", 32'(bus.imem_addr), 0);
    chk("wrap_a", 32'(bus.dmem_addr), 3);
`ifdef HACK_HALT_DETECT_EN
    load4(16'h0000, 16'h0000, 16'h0000, 16'h0004);
    rom[4] = 16'hEA87;
    do_reset();
    cyc(8);
    chk("halt_pre", 32'(bus.imem_addr), 4);
    cyc(3);
    chk("halt_flag", 32'(bus.halted), 1);
    chk("halt_pc", 32'(bus.imem_addr), 4);
    cyc(5);
    chk("halt_hold", 32'(bus.halted), 1);
    chk("halt_pc2", 32'(bus.imem_addr), 4);
    chk("halt_we", 32'(bus.dmem_we), 0);
`else
    load4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    rom[4] = 16'h0004;
    rom[5] = 16'hEA87;
    do_reset();
    cyc(8);
    chk("loop_8", 32'(bus.imem_addr), 4);
    cyc(2);
    chk("loop_10", 32'(bus.imem_addr), 5);
    cyc(3);
    chk("loop_13", 32'(bus.imem_addr), 4);
    cyc(2);
    chk("loop_15", 32'(bus.imem_addr), 5);
    cyc(3);
    chk("loop_18", 32'(bus.imem_addr), 4);
    chk("loop_halt", 32'(bus.halted), 0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
Multi-cycle Hack CPU control and datapath stage sitting directly upstream of the combinational ALU.
- Fetches instructions from a synchronous ROM, decodes A/C instructions and holds the A, D and PC registers.
- Drives the ALU's x, y and six control bits, then consumes out, zr and ng for writeback and jump resolution.
- Interfaces a synchronous data RAM with 1-cycle read latency.

Parameters:
PC_W, 15, instruction ROM address width; PC wraps modulo 2^PC_W.
RESET_VEC, 0, PC value after reset.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_addr  output  PC_W  ROM address (= pc).
imem_data  input  16  ROM data, valid one cycle after imem_addr.
dmem_addr  output  16  RAM address (= A register).
dmem_rdata  input  16  RAM read data, valid one cycle after dmem_addr.
dmem_wdata  output  16  RAM write data.
dmem_we  output  1  RAM write strobe, one-cycle pulse.
alu_x  output  16  ALU x operand (= D).
alu_y  output  16  ALU y operand (A, or latched M when ir[12]=1).
alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ir[11:6] in that order.
alu_out  input  16  ALU result.
alu_zr  input  1  ALU result == 0.
alu_ng  input  1  ALU result negative.
halted  output  1  halt flag (see Optional Feature; tied 0 when the feature is compiled out).

Behaviour:
- Reset values (asynchronous):
  - state = FETCH; pc = RESET_VEC; A, D, ir, m_reg = 0.
  - Outputs: dmem_we = 0, dmem_wdata = 0, all ALU controls = 0, halted = 0.
- States: FETCH, DECODE, MREAD, EXEC, HALT.
  - FETCH: imem_addr = pc. Next state is DECODE.
  - DECODE: ir <= imem_data.
    - If imem_data[15] = 0 (A-instr): A <= imem_data, pc <= pc+1, next FETCH. Total 2 cycles.
    - Else if imem_data[12] = 1: next MREAD.
    - Else: next EXEC.
  - MREAD: dmem_addr = A; m_reg <= dmem_rdata on the following edge; next EXEC.
  - EXEC: ALU inputs are presented combinationally from ir, D, A/m_reg, and alu_out is sampled this cycle.
    - ir[5] (dest A): A <= alu_out.
    - ir[4] (dest D): D <= alu_out.
    - ir[3] (dest M): dmem_we = 1, dmem_addr = old A, dmem_wdata = alu_out, for exactly this cycle.
    - Jump taken = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr). Taken: pc <= old A[PC_W-1:0]; otherwise pc <= pc+1.
    - Next state is FETCH.
- Instruction latency: C-instr takes 3 cycles, or 4 with an M operand.
- Simultaneous events:
  - dest A combined with M write or jump: the M address and the jump target use A before the update.
  - dest AD writes the same alu_out to both registers.
- Wrap-around: pc = 2^PC_W-1 increments to 0.
- ALU control outputs follow ir continuously; only EXEC results are consumed.
- Reset mid-instruction: the in-flight instruction is abandoned, no partial register or RAM write occurs, and dmem_we drops immediately.

Optional Feature:
Macro: HACK_HALT_DETECT_EN.
- Defined: in EXEC, a taken jump whose target equals the current pc enters HALT. HALT asserts halted = 1, freezes pc/A/D and holds dmem_we = 0 until reset.
- Undefined: no HALT state and halted is tied 0; a self-jump loops indefinitely through FETCH/DECODE/EXEC.

Test Plan:
- Reset: assert reset mid-EXEC of M=D -> dmem_we falls immediately. After release, imem_addr = 0, halted = 0, first DECODE two cycles later.
- ROM @5 (0x0005), D=A (0xEC10) -> alu_zx/nx/zy/ny/f/no = 1,1,0,0,0,0 in EXEC; D = 5; pc = 2 after 5 cycles.
- @7, D=A, @3, D=D+A (0xE090) -> D = 10, A = 3, no dmem_we pulse.
- With D = 10: @100 (0x0064), M=D (0xE308) -> exactly one dmem_we cycle with addr 100 and wdata 10. A then D=M (0xFC10) with RAM[100] = 10 takes 4 cycles, D = 10.
- Jump: D=-1 (0xEE90), @8, D;JLT (0xE304) -> pc = 8. Repeat with D;JGT (0xE301) -> pc = old pc+1, not taken.
- Halt: at pc 4 place @4 then 0;JMP (0xEA87) -> with HACK_HALT_DETECT_EN, halted = 1 and imem_addr frozen at 4. Without the macro, pc cycles 4,5,4,5 and halted stays 0.
